// File: rtl/draw_sprite_if.sv
`default_nettype none
// ============================================================================
//  Module      : draw_sprite_if
//  Description : Pixel-stream, sprite-control and ROM signals for draw_sprite.
//  Revision    : 1.0  initial release
// ============================================================================
interface draw_sprite_if #(
   parameter int ADDR_XW = 6,
   parameter int ADDR_YW = 6
);
   logic [11:0]                 xpos;
   logic [11:0]                 ypos;
   logic                        enable;
   logic                        mirror_x;
   logic [10:0]                 hcount_in;
   logic                        hsync_in;
   logic                        hblnk_in;
   logic [10:0]                 vcount_in;
   logic                        vsync_in;
   logic                        vblnk_in;
   logic [11:0]                 rgb_in;
   logic [11:0]                 rgb_pixel;
   logic [ADDR_YW+ADDR_XW-1:0]  pixel_addr;
   logic [10:0]                 hcount_out;
   logic                        hsync_out;
   logic                        hblnk_out;
   logic [10:0]                 vcount_out;
   logic                        vsync_out;
   logic                        vblnk_out;
   logic [11:0]                 rgb_out;
   logic                        sprite_hit;

   modport master (
      output xpos, ypos, enable, mirror_x,
      output hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
      output rgb_pixel,
      input  pixel_addr,
      input  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out,
      input  rgb_out, sprite_hit
   );

   modport slave (
      input  xpos, ypos, enable, mirror_x,
      input  hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
      input  rgb_pixel,
      output pixel_addr,
      output hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out,
      output rgb_out, sprite_hit
   );
endinterface
`default_nettype wire

// File: rtl/draw_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : draw_sprite
//  Description : Overlays a ROM-fetched sprite onto the VGA pixel stream.
//  Revision    : 1.0  initial release
// ============================================================================
module draw_sprite #(
   parameter int          SPRITE_W       = 48,
   parameter int          SPRITE_H       = 64,
   parameter int          ADDR_XW        = 6,
   parameter int          ADDR_YW        = 6,
   parameter int          ROM_LATENCY    = 1,
   parameter int          TRANSPARENT_EN = 1,
   parameter logic [11:0] KEY_COLOR      = 12'h0F0
) (
   input  wire logic       pclk,
   input  wire logic       rst,
   draw_sprite_if.slave    bus
);
   localparam logic [ADDR_XW-1:0] c_COL_MAX = ADDR_XW'(SPRITE_W - 1);

   typedef struct packed {
      logic        hit;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [11:0] rgb;
   } stage_t;

   // S1 input registers
   logic [10:0] r_hcount;
   logic        r_hsync;
   logic        r_hblnk;
   logic [10:0] r_vcount;
   logic        r_vsync;
   logic        r_vblnk;
   logic [11:0] r_rgb;

   // per-frame shadow registers
   logic [11:0] r_xpos_q;
   logic [11:0] r_ypos_q;
   logic        r_enable_q;
   logic        r_mirror_q;

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_hcount   <= '0;
         r_hsync    <= 1'b0;
         r_hblnk    <= 1'b0;
         r_vcount   <= '0;
         r_vsync    <= 1'b0;
         r_vblnk    <= 1'b0;
         r_rgb      <= '0;
         r_xpos_q   <= '0;
         r_ypos_q   <= '0;
         r_enable_q <= 1'b0;
         r_mirror_q <= 1'b0;
      end else begin
         r_hcount <= bus.hcount_in;
         r_hsync  <= bus.hsync_in;
         r_hblnk  <= bus.hblnk_in;
         r_vcount <= bus.vcount_in;
         r_vsync  <= bus.vsync_in;
         r_vblnk  <= bus.vblnk_in;
         r_rgb    <= bus.rgb_in;
         // load on the rising edge of vblank so the sprite never tears mid-frame
         if (bus.vblnk_in && !r_vblnk) begin
            r_xpos_q   <= bus.xpos;
            r_ypos_q   <= bus.ypos;
            r_enable_q <= bus.enable;
            r_mirror_q <= bus.mirror_x;
         end
      end
   end

   // 13-bit compares keep xpos+SPRITE_W from wrapping back to low columns
   logic [12:0] w_h13;
   logic [12:0] w_v13;
   logic [12:0] w_x13;
   logic [12:0] w_y13;
   logic [12:0] w_xend;
   logic [12:0] w_yend;
   logic        w_hit;
   logic [ADDR_XW-1:0] w_dx;
   logic [ADDR_YW-1:0] w_dy;
   logic [ADDR_XW-1:0] w_col;

   assign w_h13  = {2'b00, r_hcount};
   assign w_v13  = {2'b00, r_vcount};
   assign w_x13  = {1'b0, r_xpos_q};
   assign w_y13  = {1'b0, r_ypos_q};
   assign w_xend = w_x13 + 13'(SPRITE_W);
   assign w_yend = w_y13 + 13'(SPRITE_H);

   assign w_hit = r_enable_q & ~r_hblnk & ~r_vblnk
                & (w_h13 >= w_x13) & (w_h13 < w_xend)
                & (w_v13 >= w_y13) & (w_v13 < w_yend);

   assign w_dx  = ADDR_XW'(w_h13 - w_x13);
   assign w_dy  = ADDR_YW'(w_v13 - w_y13);
   assign w_col = r_mirror_q ? (c_COL_MAX - w_dx) : w_dx;

   assign bus.pixel_addr = w_hit ? {w_dy, w_col} : '0;

   // delay line matching the ROM read latency
   stage_t w_s1;
   stage_t r_pipe [ROM_LATENCY];
   stage_t w_d;

   assign w_s1 = {w_hit, r_hcount, r_hsync, r_hblnk, r_vcount, r_vsync, r_vblnk, r_rgb};

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 0; i < ROM_LATENCY; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= w_s1;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign w_d = r_pipe[ROM_LATENCY-1];

   logic w_key;
   logic w_draw;

   assign w_key  = (TRANSPARENT_EN != 0) && (bus.rgb_pixel == KEY_COLOR);
   assign w_draw = w_d.hit & ~w_key;

   logic [10:0] r_hcount_out;
   logic        r_hsync_out;
   logic        r_hblnk_out;
   logic [10:0] r_vcount_out;
   logic        r_vsync_out;
   logic        r_vblnk_out;
   logic [11:0] r_rgb_out;
   logic        r_sprite_hit;

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_hcount_out <= '0;
         r_hsync_out  <= 1'b0;
         r_hblnk_out  <= 1'b0;
         r_vcount_out <= '0;
         r_vsync_out  <= 1'b0;
         r_vblnk_out  <= 1'b0;
         r_rgb_out    <= '0;
         r_sprite_hit <= 1'b0;
      end else begin
         r_hcount_out <= w_d.hcount;
         r_hsync_out  <= w_d.hsync;
         r_hblnk_out  <= w_d.hblnk;
         r_vcount_out <= w_d.vcount;
         r_vsync_out  <= w_d.vsync;
         r_vblnk_out  <= w_d.vblnk;
         r_rgb_out    <= w_draw ? bus.rgb_pixel : w_d.rgb;
         r_sprite_hit <= w_draw;
      end
   end

   assign bus.hcount_out = r_hcount_out;
   assign bus.hsync_out  = r_hsync_out;
   assign bus.hblnk_out  = r_hblnk_out;
   assign bus.vcount_out = r_vcount_out;
   assign bus.vsync_out  = r_vsync_out;
   assign bus.vblnk_out  = r_vblnk_out;
   assign bus.rgb_out    = r_rgb_out;
   assign bus.sprite_hit = r_sprite_hit;

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_sprite
//  Description : Self-checking bench for draw_sprite (three parameter sets).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_draw_sprite;
   localparam int MAXC = 8192;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic        rst;
   logic [11:0] t_xpos, t_ypos, t_rgb;
   logic        t_en, t_mir;
   logic [10:0] t_h, t_v;
   logic        t_hs, t_hb, t_vs, t_vb;

   logic [2:0][11:0] w_addr, w_rgb_out;
   logic [2:0][10:0] w_hc, w_vc;
   logic [2:0]       w_hs, w_hb, w_vs, w_vb, w_hit;

   // ROM contents: address itself, except one cell that holds the key colour
   function automatic logic [11:0] rom(input int a);
      return (a == 131) ? 12'h0F0 : 12'(a);
   endfunction
   function automatic int lat(input int d);
      return (d == 2) ? 3 : 1;
   endfunction
   function automatic int ten(input int d);
      return (d == 1) ? 0 : 1;
   endfunction

   // dut0: defaults, dut1: no transparency, dut2: ROM latency 3
   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         localparam int LAT = (g == 2) ? 3 : 1;
         localparam int TEN = (g == 1) ? 0 : 1;
         draw_sprite_if u_bus ();
         logic [11:0] r_rom [0:3];
         always @(posedge pclk) begin
            r_rom[0] <= rom(int'(u_bus.pixel_addr));
            for (int i = 1; i < 4; i++) r_rom[i] <= r_rom[i-1];
         end
         assign u_bus.rgb_pixel = r_rom[LAT-1];
         assign u_bus.xpos      = t_xpos;
         assign u_bus.ypos      = t_ypos;
         assign u_bus.enable    = t_en;
         assign u_bus.mirror_x  = t_mir;
         assign u_bus.hcount_in = t_h;
         assign u_bus.hsync_in  = t_hs;
         assign u_bus.hblnk_in  = t_hb;
         assign u_bus.vcount_in = t_v;
         assign u_bus.vsync_in  = t_vs;
         assign u_bus.vblnk_in  = t_vb;
         assign u_bus.rgb_in    = t_rgb;
         assign w_addr[g]    = u_bus.pixel_addr;
         assign w_rgb_out[g] = u_bus.rgb_out;
         assign w_hc[g]      = u_bus.hcount_out;
         assign w_vc[g]      = u_bus.vcount_out;
         assign w_hs[g]      = u_bus.hsync_out;
         assign w_hb[g]      = u_bus.hblnk_out;
         assign w_vs[g]      = u_bus.vsync_out;
         assign w_vb[g]      = u_bus.vblnk_out;
         assign w_hit[g]     = u_bus.sprite_hit;
         draw_sprite #(.ROM_LATENCY(LAT), .TRANSPARENT_EN(TEN)) u_dut (
            .pclk (pclk),
            .rst  (rst),
            .bus  (u_bus)
         );
      end
   endgenerate

   typedef struct {
      bit rst;
      int h, v, rgb;
      bit hs, hb, vs, vb;
      int hit, addr;
   } rec_t;
   rec_t rec [MAXC];

   typedef struct packed {
      int at_cyc;
      int dut;
      int fld;
      int val;
      int tag;
   } lit_t;
   lit_t lits [$];

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;
   int last   = 0;

   // model of the frame-latched sprite state
   int sx = 0, sy = 0;
   bit sen = 0, smir = 0, prev_vb = 0;

   function automatic int got_field(input int d, input int fld);
      case (fld)
         0:       return int'(w_addr[d]);
         1:       return int'(w_rgb_out[d]);
         2:       return int'(w_hit[d]);
         default: return int'(w_hc[d]);
      endcase
   endfunction

   task automatic check_dut(input int d, input int k);
      int j, pix;
      bit z;
      logic [11:0] e_addr, e_rgb;
      logic [10:0] e_hc, e_vc;
      logic e_hs, e_hb, e_vs, e_vb, e_hit;
      logic [49:0] got, exp;
      j = k - lat(d) - 1;
      z = (j < 0);
      for (int i = (j < 0) ? 0 : j; i <= k; i++) if (rec[i].rst) z = 1;
      e_addr = 12'(rec[k].addr);
      if (z) begin
         {e_rgb, e_hc, e_vc, e_hs, e_hb, e_vs, e_vb, e_hit} = '0;
      end else begin
         pix   = int'(rom(rec[j].addr));
         e_hit = (rec[j].hit != 0) && !(ten(d) != 0 && pix == 'h0F0);
         e_rgb = e_hit ? 12'(pix) : 12'(rec[j].rgb);
         e_hc  = 11'(rec[j].h);
         e_vc  = 11'(rec[j].v);
         e_hs  = rec[j].hs;
         e_hb  = rec[j].hb;
         e_vs  = rec[j].vs;
         e_vb  = rec[j].vb;
      end
      got = {w_addr[d], w_rgb_out[d], w_hit[d], w_hc[d], w_hs[d], w_hb[d], w_vc[d], w_vs[d], w_vb[d]};
      exp = {e_addr, e_rgb, e_hit, e_hc, e_hs, e_hb, e_vc, e_vs, e_vb};
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle%0d dut%0d outputs {addr,rgb,hit,hc,hs,hb,vc,vs,vb} got=%h required=%h",
                    k, d, got, exp);
   endtask

   // capture inputs, step the model, compare every DUT every cycle
   initial begin
      int k, dx, dy, col;
      lit_t keep [$];
      forever begin
         @(posedge pclk);
         k = cyc;
         if (k >= MAXC) begin
            $display("FAIL cycle budget exceeded at %0d", k);
            $fatal(1, "cycle budget");
         end
         rec[k].rst = rst;
         rec[k].h = int'(t_h);   rec[k].v = int'(t_v);   rec[k].rgb = int'(t_rgb);
         rec[k].hs = t_hs; rec[k].hb = t_hb; rec[k].vs = t_vs; rec[k].vb = t_vb;
         rec[k].hit = 0;   rec[k].addr = 0;
         if (rst) begin
            sx = 0; sy = 0; sen = 0; smir = 0; prev_vb = 0;
         end else begin
            if (t_vb && !prev_vb) begin
               sx = int'(t_xpos); sy = int'(t_ypos); sen = t_en; smir = t_mir;
            end
            prev_vb = t_vb;
            if (sen && !t_hb && !t_vb && rec[k].h >= sx && rec[k].h < sx + 48 &&
                rec[k].v >= sy && rec[k].v < sy + 64) begin
               dx  = (rec[k].h - sx) % 64;
               dy  = (rec[k].v - sy) % 64;
               col = smir ? (47 - dx) : dx;
               rec[k].hit  = 1;
               rec[k].addr = dy * 64 + col;
            end
         end
         cyc++;
         #1;
         for (int d = 0; d < 3; d++) check_dut(d, k);
         keep = {};
         foreach (lits[i]) begin
            if (lits[i].at_cyc == k) begin
               n_chk++;
               if (got_field(lits[i].dut, lits[i].fld) == lits[i].val) n_pass++;
               else $display("FAIL literal%0d dut%0d field%0d got=%h required=%h", lits[i].tag,
                             lits[i].dut, lits[i].fld, got_field(lits[i].dut, lits[i].fld), lits[i].val);
            end else begin
               keep.push_back(lits[i]);
            end
         end
         lits = keep;
      end
   end

   // fld: 0 pixel_addr, 1 rgb_out, 2 sprite_hit, 3 hcount_out; off counts edges after the last drive
   task automatic expect_at(input int off, input int d, input int fld, input int val, input int tag);
      lit_t l;
      l.at_cyc = last + off; l.dut = d; l.fld = fld; l.val = val; l.tag = tag;
      lits.push_back(l);
   endtask

   task automatic expect_px(input int d, input int fld, input int val, input int tag);
      expect_at((fld == 0) ? 0 : lat(d) + 1, d, fld, val, tag);
   endtask

   task automatic drive(input int h, input int v, input int hb, input int vb);
      @(negedge pclk);
      rst   = 1'b0;
      t_h   = 11'(h);
      t_v   = 11'(v);
      t_hb  = (hb != 0);
      t_vb  = (vb != 0);
      t_hs  = ((h % 8) == 3);
      t_vs  = ((v % 5) == 1);
      t_rgb = 12'((v * 37 + h * 11) ^ 'h5A5);
      last  = cyc;
   endtask

   task automatic line(input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) drive(h, v, 0, 0);
   endtask

   task automatic latch(input int x, input int y, input int en, input int mir);
      drive(0, 600, 1, 0);
      t_xpos = 12'(x);
      t_ypos = 12'(y);
      t_en   = (en != 0);
      t_mir  = (mir != 0);
      drive(0, 601, 1, 1);
      drive(0, 602, 1, 1);
      drive(0, 0, 1, 0);
   endtask

   initial begin
      rst = 1'b1; t_h = 11'd5; t_v = 11'd50; t_hs = 1'b1; t_hb = 1'b0;
      t_vs = 1'b1; t_vb = 1'b0; t_rgb = 12'hFFF;
      t_xpos = 12'd100; t_ypos = 12'd50; t_en = 1'b1; t_mir = 1'b0;
      repeat (3) @(negedge pclk);
      last = cyc - 1;
      expect_at(0, 0, 3, 0, 1);
      expect_at(0, 0, 1, 0, 2);

      // enable inputs set but never latched: nothing drawn
      line(50, 98, 99);
      drive(100, 50, 0, 0); expect_px(0, 2, 0, 3);
      line(50, 101, 105);

      latch(100, 50, 1, 0);
      line(50, 95, 99);
      drive(100, 50, 0, 0);
      expect_px(0, 0, 0, 4); expect_px(0, 1, 0, 5); expect_px(0, 2, 1, 6);
      expect_px(2, 2, 1, 7); expect_px(2, 1, 0, 8);
      line(50, 101, 147);
      drive(148, 50, 0, 0); expect_px(0, 1, 'h833, 9); expect_px(0, 2, 0, 10);
      line(50, 149, 150);

      // xpos change mid-frame has no effect until the next latch
      t_xpos = 12'd200;
      line(60, 95, 99);
      drive(100, 60, 0, 0); expect_px(0, 1, 'h280, 11); expect_px(0, 2, 1, 12);
      line(60, 101, 199);
      drive(200, 60, 0, 0); expect_px(0, 2, 0, 13);
      line(60, 201, 210);
      line(113, 140, 146);
      drive(147, 113, 0, 0); expect_px(0, 0, 'hFEF, 14);
      line(113, 148, 150);
      line(114, 98, 102);

      latch(200, 50, 1, 0);
      line(60, 95, 199);
      drive(200, 60, 0, 0); expect_px(0, 2, 1, 15); expect_px(0, 1, 'h280, 16);
      line(60, 201, 250);

      // horizontal mirror
      latch(100, 50, 1, 1);
      line(50, 98, 99);
      drive(100, 50, 0, 0); expect_px(0, 0, 47, 17);
      line(50, 101, 146);
      drive(147, 50, 0, 0); expect_px(0, 0, 0, 18); expect_px(0, 2, 1, 19);
      line(50, 148, 150);

      // colour key at sprite (3,2)
      latch(100, 50, 1, 0);
      line(52, 98, 102);
      drive(103, 52, 0, 0);
      expect_px(0, 1, 'hE54, 20); expect_px(0, 2, 0, 21);
      expect_px(1, 1, 'h0F0, 22); expect_px(1, 2, 1, 23);
      expect_px(2, 2, 0, 24);
      line(52, 104, 106);

      // near the 12-bit top: no wrap into low columns
      latch(4090, 50, 1, 0);
      line(50, 0, 9);
      drive(10, 50, 0, 0); expect_px(0, 2, 0, 25);
      line(50, 11, 1343);

      // clipped at the right edge, blanking never draws
      latch(1000, 50, 1, 0);
      line(55, 990, 1022);
      drive(1023, 55, 0, 0); expect_px(0, 2, 1, 26); expect_px(0, 1, 'h157, 27);
      for (int h = 1024; h <= 1050; h++) begin
         drive(h, 55, 1, 0);
         if (h == 1030) expect_px(0, 2, 0, 28);
      end

      // origin is legal
      latch(0, 0, 1, 0);
      drive(0, 0, 0, 0); expect_px(0, 2, 1, 29); expect_px(0, 0, 0, 30);
      line(0, 1, 50);

      // reset mid-line
      latch(100, 50, 1, 0);
      line(50, 95, 104);
      @(negedge pclk);
      rst = 1'b1; t_h = 11'd105; t_rgb = 12'hABC;
      last = cyc;
      expect_at(0, 0, 3, 0, 31); expect_at(0, 0, 1, 0, 32);
      expect_at(0, 0, 2, 0, 33); expect_at(0, 2, 1, 0, 34);
      line(50, 106, 109);
      drive(110, 50, 0, 0); expect_px(0, 2, 0, 35);
      line(50, 111, 120);
      latch(100, 50, 1, 0);
      line(50, 100, 120);

      repeat (8) drive(0, 0, 1, 0);
      @(negedge pclk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/draw_sprite.md
Name: draw_sprite

Overview:
- Overlays a parametrised-size sprite, fetched from an external pixel ROM, onto the VGA timing/RGB stream in the display pipeline.
- Adds several features:
  - sprite position, enable and horizontal-mirror are latched once per frame at vblank start, so there is no tearing;
  - an optional colour-key transparency;
  - overflow-safe hit test;
  - configurable ROM read latency.
- Timing signals pass through delayed to stay aligned with the RGB output.

Parameters:
- SPRITE_W, 48, sprite width in pixels (1..2^ADDR_XW).
- SPRITE_H, 64, sprite height in pixels (1..2^ADDR_YW).
- ADDR_XW, 6, column address bits in pixel_addr.
- ADDR_YW, 6, row address bits in pixel_addr.
- ROM_LATENCY, 1, clock cycles from pixel_addr to valid rgb_pixel (1..4).
- TRANSPARENT_EN, 1, 1 = pixels equal to KEY_COLOR are not drawn.
- KEY_COLOR, 12'h0F0, transparent colour key.

Ports:
- pclk  in  1  pixel clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- xpos  in  12  sprite left edge (screen x), sampled at frame latch.
- ypos  in  12  sprite top edge (screen y), sampled at frame latch.
- enable  in  1  sprite visible, sampled at frame latch.
- mirror_x  in  1  horizontal flip, sampled at frame latch.
- hcount_in  in  11  horizontal counter.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- vcount_in  in  11  vertical counter.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- rgb_in  in  12  background colour.
- rgb_pixel  in  12  ROM data, valid ROM_LATENCY cycles after pixel_addr.
- pixel_addr  out  ADDR_YW+ADDR_XW  ROM address, {row, col}.
- hcount_out  out  11  delayed hcount_in.
- hsync_out  out  1  delayed hsync_in.
- hblnk_out  out  1  delayed hblnk_in.
- vcount_out  out  11  delayed vcount_in.
- vsync_out  out  1  delayed vsync_in.
- vblnk_out  out  1  delayed vblnk_in.
- rgb_out  out  12  composited colour.
- sprite_hit  out  1  1 when rgb_out carries an opaque sprite pixel (aligned with rgb_out).

Behaviour:
- Reset: every pipeline register, every output (including pixel_addr, sprite_hit, rgb_out) and every shadow register clears to 0. enable_q=0, so no sprite is drawn until the first frame latch after reset. Reset asserted mid-frame is identical.
- Frame latch: on any cycle with vblnk_in=1 and S1 vblnk=0 (rising edge), the shadow registers load xpos_q, ypos_q, enable_q and mirror_q from the inputs present that cycle. Input changes at any other time have no effect until the next latch.
- Pipeline:
  - S1 registers all inputs (1 cycle).
  - pixel_addr is combinational from S1 plus the shadow registers.
  - The hit flag and all S1 timing/rgb signals are delayed ROM_LATENCY further registers.
  - The final mux result is registered into the outputs.
  - Total latency, input to every output, is ROM_LATENCY+2; it is 3 at the default.
- Hit test at S1, in 13-bit arithmetic so that xpos+SPRITE_W never wraps:
  - hit = enable_q & !hblnk & !vblnk & hcount>=xpos_q & hcount<xpos_q+SPRITE_W & vcount>=ypos_q & vcount<ypos_q+SPRITE_H.
  - Compare counts zero-extended.
- Address:
  - dx = hcount-xpos_q and dy = vcount-ypos_q, truncated to ADDR_XW and ADDR_YW bits.
  - col = mirror_q ? SPRITE_W-1-dx : dx.
  - pixel_addr = hit ? {dy, col} : 0.
- Output mux:
  - draw = hit_d & !(TRANSPARENT_EN & rgb_pixel==KEY_COLOR).
  - rgb_out = draw ? rgb_pixel : rgb_d.
  - sprite_hit = draw.
- Boundaries:
  - Sprite partly off the right or bottom edge is clipped; no wrap to x=0.
  - xpos=0 and ypos=0 are legal.
  - Blanking pixels never draw, even inside the rectangle.

Test Plan:
- Defaults; drive enable=1, xpos=100, ypos=50 with a vblank edge, then stream a frame with ROM model rgb_pixel=addr[11:0] -> at hcount=100, vcount=50: pixel_addr=0, rgb_out=12'h000, sprite_hit=1 three cycles later. At (147,113): pixel_addr={6'd63,6'd47}. At (148,50): rgb_out=rgb_in, sprite_hit=0.
- Change xpos to 200 mid-frame -> current frame still draws at x=100; the next frame, after the vblank latch, draws at x=200.
- mirror_x=1 latched; at hcount=100, vcount=50 -> pixel_addr col=47; at hcount=147 -> col=0.
- ROM returns 12'h0F0 at a hit pixel -> rgb_out=rgb_in, sprite_hit=0. Repeat with TRANSPARENT_EN=0 -> rgb_out=12'h0F0, sprite_hit=1.
- xpos=4090 (near the 12-bit top), hcount sweep 0..1343 -> no pixel drawn, no wrap hit at low hcount. Also xpos=1000 on a 1024-wide frame: columns 1000..1023 drawn, none past.
- Assert rst mid-line -> the next cycle all outputs are 0; no sprite until the next vblank latch. Run with ROM_LATENCY=3 -> latency is 5 cycles, and rgb_pixel stays aligned with hit.
